piso_tx: RTL
============

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning the data word width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port din, input, WIDTH bits, the parallel word to transmit.
REQ-005 The block SHALL have port load_valid, input, 1 bit, meaning din is valid for capture.
REQ-006 The block SHALL have port load_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-007 The block SHALL have port so, output, 1 bit, the serial data out.
REQ-008 The block SHALL have port so_valid, output, 1 bit, meaning so carries a frame bit this cycle.
REQ-009 The block SHALL have port so_last, output, 1 bit, meaning so carries the final bit of the frame.
REQ-010 The block SHALL have port busy, output, 1 bit, meaning a frame is in progress.

Function
REQ-011 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1 (the handshake).
REQ-012 Bits SHALL be sent MSB first, so that a downstream LSB-in shift register holds the word after WIDTH shifts.
REQ-013 The MSB SHALL appear on so, with so_valid=1, in the cycle immediately after the accept edge (latency 1).
REQ-014 Each subsequent bit SHALL follow one per cycle, with no gaps, until the frame completes.
REQ-015 The FSM states SHALL be IDLE, SHIFT and PARITY, the last present only per REQ-026.
REQ-016 The FSM SHALL transition IDLE->SHIFT on accept, and SHIFT->IDLE after the LSB, or SHIFT->PARITY when parity is enabled.
REQ-017 With parity enabled, the FSM SHALL transition PARITY->IDLE after the parity bit.
REQ-018 load_ready SHALL be 1 in IDLE and in the cycle in which so_last=1; it SHALL be 0 otherwise.
REQ-019 Back-to-back words SHALL be accepted during the so_last cycle and start with their MSB in the next cycle, with no idle bit between frames.
REQ-020 load_valid while load_ready=0 SHALL be ignored, and the held word SHALL NOT be altered.
REQ-021 A bit down-counter SHALL load WIDTH-1 on accept and reach 0 on the final data bit; it SHALL never wrap.
REQ-022 In IDLE, so, so_valid, so_last and busy SHALL all be 0.
REQ-023 busy SHALL be 1 exactly while so_valid=1.
REQ-024 With WIDTH=1, each frame SHALL be a single data-bit cycle with so_last=1.

Reset
REQ-025 While clear=1 at a rising edge, state SHALL go to IDLE, the counter and shift register to 0, so/so_valid/so_last/busy to 0, and load_ready SHALL be forced to 0; clear SHALL override a simultaneous load and abort any frame in progress, with load_ready=1 again in the first cycle after clear deasserts.

Configuration
REQ-026 With macro PISO_TX_PARITY_EN defined, an even-parity bit (XOR of the word) SHALL be appended after the LSB, the frame SHALL be WIDTH+1 bits, and so_last SHALL be asserted on the parity bit; undefined, the frame SHALL be WIDTH bits, so_last SHALL be on the LSB, and no PARITY state or parity logic SHALL exist.

Structure
REQ-027 Package piso_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PARITY) and the default WIDTH constant.
REQ-028 The bit counter SHALL be one sub-module, piso_bit_cnt, with load, decrement and zero-flag signals; all other logic SHALL be in piso_tx.

Verification
REQ-029 With WIDTH=8, no parity: load 0xA5 -> so = 1,0,1,0,0,1,0,1 over 8 cycles, so_last on cycle 8, then IDLE.
REQ-030 Back-to-back: 0xA5, then 0x3C presented during so_last -> 16 contiguous so_valid cycles, second frame 0,0,1,1,1,1,0,0.
REQ-031 Load attempt mid-frame: assert load_valid with 0xFF at bit 3 of 0xA5 -> ignored; 0xA5 stream is unchanged.
REQ-032 Clear mid-frame: assert clear at bit 4 -> next cycle all outputs 0, IDLE; after release load_ready=1 and 0x81 transmits cleanly.
REQ-033 With PISO_TX_PARITY_EN: 0xA5 -> 9th bit 0, so_last on it; 0x07 -> 9th bit 1.
REQ-034 With WIDTH=1: loading 1 then 0 back-to-back -> so = 1,0, with so_last=1 on both cycles.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state encoding and default word width for the
// serial transmitter. The PARITY encoding is reachable only when
// PISO_TX_PARITY_EN is defined.
package piso_pkg;

    localparam int PISO_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: bit down-counter for the serial transmitter. Loads WIDTH-1
// when a word is accepted and counts down once per shifted bit. It saturates
// at zero instead of wrapping, so a held decrement after the last bit is
// harmless.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter  int WIDTH = PISO_WIDTH_DEFAULT,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Load has priority over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WIDTH - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter. A word is captured on a
// load_valid/load_ready handshake and sent MSB first, one bit per cycle,
// starting the cycle after the accept edge. A new word may be accepted in
// the cycle carrying so_last, so frames can run back to back with no gap.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// (XOR of the word) after the LSB; so_last then marks the parity bit.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign accept = load_valid & load_ready;

    piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk   (clk),
        .clear (clear),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    // FSM state register; clear aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a word accepted on the last bit chains straight into SHIFT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_zero) begin
`ifdef PISO_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                state_d = accept ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: serial bit comes straight from the shift register MSB.
    always_comb begin
        so       = 1'b0;
        so_last  = 1'b0;
        so_valid = (state_q != IDLE);
        busy     = (state_q != IDLE);
        case (state_q)
            SHIFT: begin
                so = shreg_q[WIDTH-1];
`ifndef PISO_TX_PARITY_EN
                so_last = cnt_zero;
`endif
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                so      = par_q;
                so_last = 1'b1;
            end
`endif
            default: ;
        endcase
        // Ready in IDLE and on the final frame bit, never while clear is held.
        load_ready = ~clear & ((state_q == IDLE) | so_last);
    end

    // Datapath next state: capture on accept, otherwise shift left while in SHIFT.
    always_comb begin
        shreg_d  = shreg_q;
        cnt_load = accept;
        cnt_dec  = (state_q == SHIFT);
        if (accept) begin
            shreg_d = din;
        end else if (state_q == SHIFT) begin
            shreg_d = shreg_q << 1;
        end
`ifdef PISO_TX_PARITY_EN
        par_d = par_q;
        if (accept) par_d = ^din;
`endif
    end

    // Datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            shreg_q <= '0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            shreg_q <= shreg_d;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
